// File: rtl/instruction_cache.sv
// rtl/instruction_cache.sv - direct-mapped instruction cache in front of a 128-bit line memory
//
// Purpose:
//   Answers one 32-bit instruction fetch at a time. Hits respond one cycle
//   after acceptance. Misses drive the line address to the instruction memory,
//   wait MEM_WAIT cycles for the line, store it un-permuted, and respond.
//
// Ports:
//   clk           clock, all state on posedge
//   reset         synchronous active-high reset
//   req_valid     fetch request present
//   req_addr      byte address of the fetch (bits[1:0] ignored)
//   req_ready     high only while idle; accept = req_valid & req_ready
//   flush         invalidate every line
//   resp_valid    one-cycle pulse per accepted request
//   resp_addr     word-aligned address of the answered request
//   resp_instr    instruction word
//   mem_address   line address to the instruction memory (low 4 bits zero)
//   mem_dataline  line returned by the instruction memory (permuted order)

module instruction_cache #(
    parameter int LINES    = 8,
    parameter int MEM_WAIT = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic [31:0]  req_addr,
    output logic         req_ready,
    input  logic         flush,
    output logic         resp_valid,
    output logic [31:0]  resp_addr,
    output logic [31:0]  resp_instr,
    output logic [31:0]  mem_address,
    input  logic [127:0] mem_dataline
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 28 - IDX_W;
    localparam int CNT_W = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [127:0]       data_mem [LINES];

    logic [CNT_W-1:0]   wait_cnt;
    logic [31:0]        pend_addr;
    // Remembers a flush seen during the current fill so the filled line is
    // written but left invalid.
    logic               fill_flushed;

    logic [31:0]        req_word_addr;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               accept;
    logic               hit;
    logic               fill_done;
    logic [127:0]       fill_line;

    // Pick one 32-bit word out of an un-permuted line by word offset.
    function automatic logic [31:0] sel_word(input logic [127:0] line,
                                             input logic [1:0]   off);
        logic [31:0] w;
        case (off)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            default: w = line[127:96];
        endcase
        return w;
    endfunction

    assign req_word_addr = req_addr & 32'hFFFF_FFFC;
    assign req_idx       = req_word_addr[3+IDX_W:4];
    assign req_tag       = req_word_addr[31:4+IDX_W];
    assign fill_idx      = pend_addr[3+IDX_W:4];
    assign fill_tag      = pend_addr[31:4+IDX_W];

    assign accept    = req_valid && req_ready;
    // A flush on the accept edge wipes the line, so the request must miss.
    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;
    assign fill_done = (state == FILL) && (wait_cnt == CNT_W'(MEM_WAIT));

    // Memory order is word0, word2, word1, word3 from the low bits upward;
    // swap the middle two words back into address order.
    assign fill_line = {mem_dataline[127:96], mem_dataline[63:32],
                        mem_dataline[95:64],  mem_dataline[31:0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !hit) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (fill_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = 1'b0;
        if (state == IDLE) begin
            req_ready = 1'b1;
        end
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            valid        <= '0;
            wait_cnt     <= '0;
            pend_addr    <= '0;
            fill_flushed <= 1'b0;
            resp_valid   <= 1'b0;
            resp_addr    <= '0;
            resp_instr   <= '0;
            mem_address  <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (flush) begin
                valid <= '0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            resp_valid <= 1'b1;
                            resp_addr  <= req_word_addr;
                            resp_instr <= sel_word(data_mem[req_idx], req_word_addr[3:2]);
                        end else begin
                            pend_addr    <= req_word_addr;
                            mem_address  <= {req_word_addr[31:4], 4'b0000};
                            wait_cnt     <= '0;
                            fill_flushed <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    if (fill_done) begin
                        wait_cnt   <= '0;
                        resp_valid <= 1'b1;
                        resp_addr  <= pend_addr;
                        resp_instr <= sel_word(fill_line, pend_addr[3:2]);
                        if (!fill_flushed && !flush) begin
                            valid[fill_idx] <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (flush) begin
                            fill_flushed <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage has no reset; the valid bits alone decide what is usable.
    always_ff @(posedge clk) begin
        if (!reset && fill_done) begin
            data_mem[fill_idx] <= fill_line;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// tb/tb_instruction_cache.sv - scoreboard bench for instruction_cache

module tb_instruction_cache;

    localparam int LINES    = 8;
    localparam int MEM_WAIT = 7;
    localparam int MISS_LAT = MEM_WAIT + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         req_ready;
    logic         flush;
    logic         resp_valid;
    logic [31:0]  resp_addr;
    logic [31:0]  resp_instr;
    logic [31:0]  mem_address;
    logic [127:0] mem_dataline;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          edge_n;
    } exp_t;

    exp_t q[$];

    instruction_cache #(
        .LINES    (LINES),
        .MEM_WAIT (MEM_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_addr    (resp_addr),
        .resp_instr   (resp_instr),
        .mem_address  (mem_address),
        .mem_dataline (mem_dataline)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory image: byte i holds i % 200, little-endian words.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        int unsigned base;
        base = a & 32'hFFFF_FFFC;
        for (int k = 0; k < 4; k++) begin
            w[8*k +: 8] = 8'((base + k) % 200);
        end
        return w;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        logic [31:0] l;
        l = a & 32'hFFFF_FFF0;
        return {word_at(l + 12), word_at(l + 4), word_at(l + 8), word_at(l)};
    endfunction

    // Memory returns the line for an address only MEM_WAIT cycles after it changes.
    logic [31:0] pipe [MEM_WAIT];
    initial begin
        for (int i = 0; i < MEM_WAIT; i++) pipe[i] = 32'hDEAD_0000;
    end
    always @(posedge clk) begin
        pipe[0] <= mem_address;
        for (int i = 1; i < MEM_WAIT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_dataline = mem_line(pipe[MEM_WAIT-1]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("spurious_resp", {31'b0, resp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("resp_addr", resp_addr, e.addr);
                check("resp_instr", resp_instr, e.instr);
                check("resp_edge", 32'(cyc), 32'(e.edge_n));
            end
        end
    end

    // Issue one request starting at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [31:0] a, input int lat, input bit do_flush,
                         input bit want_resp, output int waited);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", {31'b0, req_ready}, 32'd1);
        waited    = n;
        req_valid = 1'b1;
        req_addr  = a;
        flush     = do_flush;
        if (want_resp) q.push_back('{a & 32'hFFFF_FFFC, word_at(a), cyc + 1 + lat});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("resp_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_addr", resp_addr, 32'd0);
        check("rst_resp_instr", resp_instr, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);

        // Cold fetch and un-permute
        issue(32'h000, MISS_LAT, 0, 1, w);
        wait_idle();
        issue(32'h004, 0, 0, 1, w);
        issue(32'h008, 0, 0, 1, w);
        issue(32'h00C, 0, 0, 1, w);
        wait_idle();

        // Conflict on index 0
        issue(32'h080, MISS_LAT, 0, 1, w);
        wait_idle();
        issue(32'h084, 0, 0, 1, w);
        wait_idle();
        issue(32'h000, MISS_LAT, 0, 1, w);
        wait_idle();
        issue(32'h084, MISS_LAT, 0, 1, w);
        wait_idle();

        // Hit streak on consecutive cycles
        issue(32'h010, MISS_LAT, 0, 1, w);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            issue(32'h010 + 32'(4 * i), 0, 0, 1, w);
            check("streak_ready_wait", 32'(w), 32'd0);
        end
        wait_idle();

        // Flush during fill: response still delivered, line left invalid
        issue(32'h0C8, MISS_LAT, 0, 1, w);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_idle();
        issue(32'h0C8, MISS_LAT, 0, 1, w);
        wait_idle();
        issue(32'h0C8, 0, 0, 1, w);
        wait_idle();
        // Flush on the accept edge forces a miss
        issue(32'h0C8, MISS_LAT, 1, 1, w);
        wait_idle();

        // Reset mid-fill at wait_cnt == 3
        issue(32'h000, MISS_LAT, 0, 1, w);
        wait_idle();
        issue(32'h000, 0, 0, 1, w);
        wait_idle();
        issue(32'h040, MISS_LAT, 0, 0, w);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("mid_rst_resp_addr", resp_addr, 32'd0);
        check("mid_rst_resp_instr", resp_instr, 32'd0);
        check("mid_rst_mem_address", mem_address, 32'd0);
        repeat (12) @(negedge clk);
        issue(32'h000, MISS_LAT, 0, 1, w);
        wait_idle();
        issue(32'h004, 0, 0, 1, w);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped instruction cache between the fetch stage and the 128-bit line-based instruction memory. It accepts one word-fetch request at a time and answers hits one cycle after acceptance. On a miss it drives the line address to the memory, waits the memory's fixed fill latency, and writes the returned 16-byte line. It also un-permutes the memory's word ordering and returns the requested 32-bit instruction.

## Interface
Parameters:
- LINES, 8: number of cache lines; power of two ≥ 2; index = addr[3+log2(LINES):4].
- MEM_WAIT, 7: cycles from driving a new mem_address until mem_dataline is stable; the cache samples on the following edge.

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  fetch request present.
- req_addr  in  32  byte address; bits[1:0] ignored.
- req_ready  out  1  high only in IDLE; request accepted on edge with req_valid & req_ready.
- flush  in  1  invalidate all lines.
- resp_valid  out  1  one-cycle pulse per accepted request; no backpressure.
- resp_addr  out  32  req_addr of the answered request, bits[1:0] forced 0.
- resp_instr  out  32  instruction word.
- mem_address  out  32  line address to instruction memory, low 4 bits always 0.
- mem_dataline  in  128  line from instruction memory.

## Operation
- Storage per line: valid bit, tag = addr[31:4+log2(LINES)], 128-bit data stored already un-permuted.
- mem_dataline word order: bits[31:0]=word0 (offset 0x0), [63:32]=word2 (0x8), [95:64]=word1 (0x4), [127:96]=word3 (0xC).
- Each word is little-endian; the byte at the lowest address sits in bits[7:0].
- resp_instr selection uses addr[3:2] into the un-permuted line.
- States: IDLE, FILL.
- IDLE with accepted request:
  - Tag compare happens against req_addr in the same cycle.
  - Hit: register resp_valid=1, resp_addr and resp_instr; stay in IDLE.
  - Miss: latch the request; mem_address <= {req_addr[31:4],4'b0}; wait_cnt <= 0; go to FILL.
- FILL:
  - req_ready=0; wait_cnt increments each edge.
  - At the edge where wait_cnt==MEM_WAIT, capture mem_dataline into the indexed line and set valid and tag.
  - On that same edge, issue the response from the captured data and return to IDLE.
- mem_address holds its value between fills. A re-miss to the same line address still waits the full MEM_WAIT; the memory does not refetch, but its dataline already holds that line.
- flush in IDLE: clear all valid bits on the same edge. A request accepted on that edge is treated as a miss.
- flush in FILL:
  - Clear all valid bits.
  - The fill still completes and the response is delivered, but the filled line is left invalid.
- A conflicting line is overwritten silently; there is no write path.

## Timing
- Reset values:
  - State IDLE; all valid bits 0; wait_cnt 0.
  - req_ready 1 after reset release; resp_valid 0; resp_addr 0; resp_instr 0; mem_address 0.
- Hit latency: accept at edge A, resp_valid high for the cycle after A.
- Back-to-back hits give one response per cycle.
- Miss latency with MEM_WAIT=7: accept at A, mem_address changes after A, line captured and resp_valid high after edge A+8.
- req_ready returns high in the same cycle resp_valid pulses for a miss.
- resp_valid is never high for more than one cycle per request.
- Reset mid-FILL: return to IDLE, clear valid bits, no response for the aborted request.

## Test plan
Memory contents for every scenario: byte i = i%200.
- Cold fetch 0x000: 8-cycle miss, resp_instr=0x03020100. Then 0x004, 0x008, 0x00C as 1-cycle hits returning 0x07060504, 0x0B0A0908, 0x0F0E0D0C; this proves the un-permute.
- Conflict (LINES=8):
  - 0x000 then 0x080 both miss; 0x080 returns 0x83828180.
  - 0x000 again misses with 0x03020100.
  - 0x084 hits with 0x87868584.
- Hit streak: fill 0x010, then 4 consecutive requests 0x010, 0x014, 0x018, 0x01C hit on 4 consecutive cycles.
  - Expected responses: 0x13121110, 0x17161514, 0x1B1A1918, 0x1F1E1D1C.
  - req_ready stays 1 throughout.
- Flush during FILL of 0x0C8:
  - The response is still 0x03020100 (bytes 200..203 map to 0,1,2,3).
  - The next 0x0C8 request misses again.
- Reset asserted at wait_cnt=3:
  - No resp_valid.
  - Outputs return to reset values.
  - The next 0x000 request takes the full miss latency.
